// File: rtl/cardio_feature_loader_if.sv
// cardio_feature_loader_if: host-side bundle for the cardio feature loader.
// Stream in: s_valid/s_data/s_last/s_ready. Result out: m_valid/m_class/m_ready.
interface cardio_feature_loader_if #(
  parameter int FEAT_W = 8
) ();
  logic              s_valid;
  logic [FEAT_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              m_valid;
  logic [1:0]        m_class;
  logic              m_ready;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_class
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_class
  );
endinterface

// File: rtl/cardio_feature_loader.sv
// cardio_feature_loader: assembles a byte-streamed feature vector for the
// cardio decision tree, waits a settle time, and returns the tree's class.
// Ports: clk, rst (sync, active-high); bus (slave: stream in, result out);
//   feat_bus/feat_valid to the tree; tree_class from the tree; frame_err pulse.
// Optional CARDIO_CLASS_STATS_EN adds stats_clr in and class_cnt (4x16) out.
module cardio_feature_loader #(
  parameter int                   NUM_FEAT   = 20,
  parameter int                   FEAT_W     = 8,
  parameter logic [NUM_FEAT-1:0]  FEAT_MASK  = 20'hFFFCF,
  parameter int                   SETTLE_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  cardio_feature_loader_if.slave     bus,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
  output logic                       feat_valid,
  input  logic [1:0]                 tree_class,
  output logic                       frame_err
`ifdef CARDIO_CLASS_STATS_EN
  ,
  input  logic                       stats_clr,
  output logic [63:0]                class_cnt
`endif
);

  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    SETTLE,
    RESULT
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_FEAT*FEAT_W-1:0] bus_d;
  logic                       fv_d;
  logic                       mv_d;
  logic [1:0]                 mc_d;
  logic                       err_d;
  logic                       sr_d;
  logic                       xfer;
  logic                       hs;

  assign xfer = bus.s_valid && bus.s_ready;
  assign hs   = bus.m_valid && bus.m_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bus_d   = feat_bus;
    fv_d    = feat_valid;
    mv_d    = bus.m_valid;
    mc_d    = bus.m_class;
    err_d   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (xfer) begin
          // Unused slots stay zero so the tree never sees stale bytes.
          if (FEAT_MASK[idx_q])
            bus_d[idx_q*FEAT_W +: FEAT_W] = bus.s_data;
          if (idx_q == LAST_IDX) begin
            if (bus.s_last) begin
              state_d = SETTLE;
              fv_d    = 1'b1;
              cnt_d   = CNT_INIT;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (bus.s_last) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (xfer && bus.s_last) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          mc_d    = tree_class;
          mv_d    = 1'b1;
          state_d = RESULT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESULT: begin
        if (hs) begin
          mv_d    = 1'b0;
          fv_d    = 1'b0;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
    // s_ready is a flop fed from the next state, so m_ready never
    // reaches it combinationally.
    sr_d = (state_d == LOAD) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      feat_bus    <= '0;
      feat_valid  <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_class <= 2'd0;
      frame_err   <= 1'b0;
      bus.s_ready <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      feat_bus    <= bus_d;
      feat_valid  <= fv_d;
      bus.m_valid <= mv_d;
      bus.m_class <= mc_d;
      frame_err   <= err_d;
      bus.s_ready <= sr_d;
    end
  end

`ifdef CARDIO_CLASS_STATS_EN
  logic [15:0] cnt_arr [4];

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      for (int c = 0; c < 4; c++)
        cnt_arr[c] <= '0;
    end else if (hs) begin
      if (cnt_arr[bus.m_class] != 16'hFFFF)
        cnt_arr[bus.m_class] <= cnt_arr[bus.m_class] + 16'd1;
    end
  end

  always_comb begin
    class_cnt = '0;
    for (int c = 0; c < 4; c++)
      class_cnt[c*16 +: 16] = cnt_arr[c];
  end
`endif

endmodule

// File: tb/tb_cardio_feature_loader.sv
// tb_cardio_feature_loader: directed bench with a result scoreboard
// for cardio_feature_loader.
module tb_cardio_feature_loader;
  localparam int NF = 20;
  localparam int FW = 8;
  localparam int SC = 2;
  localparam logic [NF-1:0] MASK = 20'hFFFCF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cardio_feature_loader_if #(.FEAT_W(FW)) bus ();
  logic [NF*FW-1:0] feat_bus;
  logic             feat_valid;
  logic             frame_err;
  logic [1:0]       tree_class;
`ifdef CARDIO_CLASS_STATS_EN
  logic             stats_clr;
  logic [63:0]      class_cnt;
  int               exp_cnt [4];
`endif

  cardio_feature_loader #(
    .NUM_FEAT(NF), .FEAT_W(FW), .FEAT_MASK(MASK), .SETTLE_CYC(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .feat_bus(feat_bus),
    .feat_valid(feat_valid),
    .tree_class(tree_class),
    .frame_err(frame_err)
`ifdef CARDIO_CLASS_STATS_EN
    ,
    .stats_clr(stats_clr),
    .class_cnt(class_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [FW-1:0] exp_feat [NF];
  int  m_idx;
  bit  m_drain;
  logic [1:0] exp_q [$];

  task automatic chk(input string tag, input logic [NF*FW-1:0] obs,
                     input logic [NF*FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NF*FW-1:0] exp_bus();
    logic [NF*FW-1:0] v;
    v = '0;
    for (int i = 0; i < NF; i++)
      v[i*FW +: FW] = exp_feat[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++)
      exp_feat[i] = '0;
    m_idx = 0;
    m_drain = 0;
    exp_q.delete();
`ifdef CARDIO_CLASS_STATS_EN
    for (int c = 0; c < 4; c++)
      exp_cnt[c] = 0;
`endif
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.m_ready = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk("rst_feat_bus", feat_bus, '0);
    chk("rst_feat_valid", feat_valid, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_class", bus.m_class, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_s_ready", bus.s_ready, 1);
`ifdef CARDIO_CLASS_STATS_EN
    chk("rst_class_cnt", class_cnt, 0);
`endif
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [FW-1:0] d, input bit last);
    bit exp_err;
    bit done;
    exp_err = 0;
    done = 0;
    bus.s_valid = 1'b1;
    bus.s_data = d;
    bus.s_last = last;
    chk("s_ready_load", bus.s_ready, 1);
    if (!m_drain) begin
      exp_feat[m_idx] = MASK[m_idx] ? d : '0;
      if (m_idx == NF - 1) begin
        if (last) done = 1;
        else begin
          exp_err = 1;
          m_drain = 1;
        end
        m_idx = 0;
      end else if (last) begin
        exp_err = 1;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end else if (last) begin
      m_drain = 0;
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    chk("frame_err", frame_err, exp_err);
    chk("feat_valid_beat", feat_valid, done);
    if (done) exp_q.push_back(tree_class);
  endtask

  task automatic send_frame(input int n, input int last_at, input int base);
    for (int i = 0; i < n; i++)
      send_beat(FW'(base + i * 3), i == last_at);
  endtask

  task automatic wait_result(input int hold, input bit clr);
    int n;
    logic [1:0] e;
    chk("fv_settle", feat_valid, 1);
    chk("s_ready_settle", bus.s_ready, 0);
    chk("m_valid_early", bus.m_valid, 0);
    chk("bus_settle", feat_bus, exp_bus());
    n = 0;
    while (!bus.m_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("settle_lat", n, SC);
    chk("m_valid", bus.m_valid, 1);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
      e = 2'd0;
    end else begin
      e = exp_q.pop_front();
    end
    chk("m_class", bus.m_class, e);
    bus.s_valid = 1'b1;
    bus.s_data = 8'hA5;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_s_ready", bus.s_ready, 0);
      chk("hold_m_valid", bus.m_valid, 1);
      chk("hold_m_class", bus.m_class, e);
      chk("hold_bus", feat_bus, exp_bus());
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
`ifdef CARDIO_CLASS_STATS_EN
    stats_clr = clr;
`endif
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
`ifdef CARDIO_CLASS_STATS_EN
    stats_clr = 1'b0;
    if (clr) begin
      for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
    end else if (exp_cnt[e] < 16'hFFFF) begin
      exp_cnt[e]++;
    end
    for (int c = 0; c < 4; c++)
      chk("class_cnt", class_cnt[c*16 +: 16], exp_cnt[c]);
`else
    if (clr) chk("clr_unused", 0, 0);
`endif
    chk("hs_m_valid", bus.m_valid, 0);
    chk("hs_feat_valid", feat_valid, 0);
    chk("hs_s_ready", bus.s_ready, 1);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    bus.m_ready = 1'b0;
    tree_class = 2'd2;
`ifdef CARDIO_CLASS_STATS_EN
    stats_clr = 1'b0;
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    reset_dut();

    // Basic frame, data = i*3, class 2.
    send_frame(NF, NF - 1, 0);
    chk("slice3", feat_bus[3*FW +: FW], 9);
    chk("slice4", feat_bus[4*FW +: FW], 0);
    chk("slice5", feat_bus[5*FW +: FW], 0);
    wait_result(0, 0);

    // Short frame then a good frame.
    tree_class = 2'd1;
    send_frame(8, 7, 100);
    chk("short_no_fv", feat_valid, 0);
    send_frame(NF, NF - 1, 7);
    wait_result(0, 0);

    // Long frame: 23 beats, no result.
    send_frame(23, 22, 50);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("long_no_result", bus.m_valid, 0);
      chk("long_s_ready", bus.s_ready, 1);
    end
    tree_class = 2'd3;
    send_frame(NF, NF - 1, 11);
    wait_result(10, 0);

    // Reset during SETTLE.
    tree_class = 2'd0;
    send_frame(NF, NF - 1, 33);
    reset_dut();
    send_frame(NF, NF - 1, 3);
    wait_result(0, 0);

    // Reset mid-LOAD at beat 10.
    send_frame(10, -1, 90);
    reset_dut();
    tree_class = 2'd2;
    send_frame(NF, NF - 1, 200);
    wait_result(2, 0);

`ifdef CARDIO_CLASS_STATS_EN
    reset_dut();
    tree_class = 2'd1;
    for (int f = 0; f < 3; f++) begin
      send_frame(NF, NF - 1, f);
      wait_result(0, 0);
    end
    tree_class = 2'd3;
    send_frame(NF, NF - 1, 40);
    wait_result(0, 0);
    chk("cnt1_total", class_cnt[16 +: 16], 3);
    chk("cnt3_total", class_cnt[48 +: 16], 1);
    send_frame(NF, NF - 1, 60);
    wait_result(0, 1);
    chk("cnt_cleared", class_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
